register_pipeline: RTL and testbench

REGISTER_PIPELINE -- requirements
Module: Register_Pipeline

---
 rtl/register_pipeline.sv | 70 +++++++
 tb/tb_register_pipeline.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_pipeline.sv
// Shift-register pipeline of DEPTH stages, each a data word plus valid bit, with an
// occupancy counter and a combinational tap into any stage.
module register_pipeline #(
    parameter int unsigned WORD_LENGTH  = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ZERO_BUBBLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           Rst,
    input  logic                           Enable,
    input  logic                           Valid_In,
    input  logic [WORD_LENGTH-1:0]         Data_Input,
    input  logic [$clog2(DEPTH)-1:0]       Tap_Sel,
    output logic [WORD_LENGTH-1:0]         Data_Output,
    output logic                           Valid_Output,
    output logic [WORD_LENGTH-1:0]         Tap_Output,
    output logic                           Tap_Valid,
    output logic [$clog2(DEPTH+1)-1:0]     Occupancy,
    output logic                           Full,
    output logic                           Empty
);

    localparam int unsigned SEL_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WORD_LENGTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [OCC_W-1:0]       occ_q;

    always_ff @(posedge clk) begin
        if (reset || Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else if (Enable) begin
            data_q[0] <= (ZERO_BUBBLES != 0 && !Valid_In) ? '0 : Data_Input;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_q[i] <= (ZERO_BUBBLES != 0 && !valid_q[i-1]) ? '0 : data_q[i-1];
            end
            valid_q <= {valid_q[DEPTH-2:0], Valid_In};
            // Entry and exit on the same edge cancel; the guards keep the count in range.
            if (Valid_In && !valid_q[DEPTH-1] && occ_q != OCC_W'(DEPTH)) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (!Valid_In && valid_q[DEPTH-1] && occ_q != '0) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

    always_comb begin
        Tap_Output = '0;
        Tap_Valid  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (Tap_Sel == SEL_W'(i)) begin
                Tap_Output = data_q[i];
                Tap_Valid  = valid_q[i];
            end
        end
    end

    assign Data_Output  = data_q[DEPTH-1];
    assign Valid_Output = valid_q[DEPTH-1];
    assign Occupancy    = occ_q;
    assign Full         = (occ_q == OCC_W'(DEPTH));
    assign Empty        = (occ_q == '0);

endmodule

// File: tb/tb_register_pipeline.sv
// Directed self-checking bench for register_pipeline (DEPTH=4 main build, DEPTH=3 tap build).
module tb_register_pipeline;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic       flush;
    logic       enable;
    logic       valid_in;
    logic [7:0] data_in;
    logic [1:0] tap_sel;
    logic [1:0] tap_sel3;

    logic [7:0] data_out, tap_out, data_out3, tap_out3;
    logic       valid_out, tap_valid, full, empty;
    logic       valid_out3, tap_valid3, full3, empty3;
    logic [2:0] occ;
    logic [1:0] occ3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_pipeline #(.WORD_LENGTH(8), .DEPTH(4), .ZERO_BUBBLES(1)) dut (
        .clk(clk), .reset(sys_reset), .Rst(flush), .Enable(enable), .Valid_In(valid_in),
        .Data_Input(data_in), .Tap_Sel(tap_sel), .Data_Output(data_out),
        .Valid_Output(valid_out), .Tap_Output(tap_out), .Tap_Valid(tap_valid),
        .Occupancy(occ), .Full(full), .Empty(empty)
    );

    register_pipeline #(.WORD_LENGTH(8), .DEPTH(3), .ZERO_BUBBLES(1)) dut3 (
        .clk(clk), .reset(sys_reset), .Rst(flush), .Enable(enable), .Valid_In(valid_in),
        .Data_Input(data_in), .Tap_Sel(tap_sel3), .Data_Output(data_out3),
        .Valid_Output(valid_out3), .Tap_Output(tap_out3), .Tap_Valid(tap_valid3),
        .Occupancy(occ3), .Full(full3), .Empty(empty3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1; enable = 1'b0; valid_in = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1; flush = 1'b0; enable = 1'b0; valid_in = 1'b0;
        data_in = 8'h00; tap_sel = 2'd0; tap_sel3 = 2'd0;
        tick();
        checks++;
        if ({data_out, valid_out, occ, empty, full} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: dout=%h vout=%b occ=%0d empty=%b full=%b, need 00 0 0 1 0",
                     data_out, valid_out, occ, empty, full);
        end
        sys_reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] din   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        logic [7:0] edout [5] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        logic [2:0] eocc  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        do_flush();
        enable = 1'b1; valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = din[k];
            tick();
            checks++;
            if ({data_out, valid_out, occ, full} !== {edout[k], k >= 3, eocc[k], k >= 3}) begin
                errors++;
                $display("FAIL fill edge %0d: dout=%h vout=%b occ=%0d full=%b, need %h %b %0d %b",
                         k + 1, data_out, valid_out, occ, full, edout[k], k >= 3, eocc[k], k >= 3);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_stall();
        do_flush();
        enable = 1'b1; valid_in = 1'b1; data_in = 8'hA1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_in = (k % 2 == 0) ? 8'h5A : 8'hC3;
            tick();
            checks++;
            if ({occ, valid_out, data_out} !== {3'd1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL stall hold %0d: occ=%0d vout=%b dout=%h, need 1 0 00",
                         k, occ, valid_out, data_out);
            end
        end
        enable = 1'b1; valid_in = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if ({data_out, valid_out} !== {(k == 4) ? 8'hA1 : 8'h00, k == 4}) begin
                errors++;
                $display("FAIL stall enabled edge %0d: dout=%h vout=%b", k, data_out, valid_out);
            end
        end
        tick();
        checks++;
        if ({occ, empty, valid_out} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall drain: occ=%0d empty=%b vout=%b, need 0 1 0", occ, empty, valid_out);
        end
        enable = 1'b0;
    endtask

    task automatic test_bubbles();
        logic       vin [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] din [4] = '{8'h0F, 8'hFF, 8'hF0, 8'hFF};
        // Expected stage contents indexed by stage number.
        logic [7:0] esd [4] = '{8'h00, 8'hF0, 8'h00, 8'h0F};
        logic       esv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_flush();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            valid_in = vin[k]; data_in = din[k];
            tick();
        end
        enable = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s);
            #1;
            checks++;
            if ({tap_out, tap_valid} !== {esd[s], esv[s]}) begin
                errors++;
                $display("FAIL bubbles stage %0d: data=%h valid=%b, need %h %b",
                         s, tap_out, tap_valid, esd[s], esv[s]);
            end
        end
        checks++;
        if ({occ, data_out, valid_out} !== {3'd2, 8'h0F, 1'b1}) begin
            errors++;
            $display("FAIL bubbles occ: occ=%0d dout=%h vout=%b, need 2 0F 1", occ, data_out, valid_out);
        end
    endtask

    task automatic test_flush_priority();
        do_flush();
        enable = 1'b1; valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = 8'(k + 8'h61);
            tick();
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL flush prefill: full=%b, need 1", full);
        end
        flush = 1'b1; data_in = 8'h99;
        tick();
        flush = 1'b0;
        checks++;
        if ({occ, empty, full, data_out, valid_out} !== {3'd0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL flush clear: occ=%0d empty=%b full=%b dout=%h vout=%b",
                     occ, empty, full, data_out, valid_out);
        end
        enable = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s);
            #1;
            checks++;
            if ({tap_out, tap_valid} !== {8'h00, 1'b0}) begin
                errors++;
                $display("FAIL flush stage %0d: data=%h valid=%b, need 00 0", s, tap_out, tap_valid);
            end
        end
        enable = 1'b1; valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({data_out, valid_out} !== {8'h00, 1'b0}) begin
                errors++;
                $display("FAIL flush drain %0d: dout=%h vout=%b, need 00 0", k, data_out, valid_out);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_tap();
        logic [7:0] etap [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
        do_flush();
        enable = 1'b1; valid_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            data_in = 8'(k);
            tick();
        end
        enable = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s);
            #1;
            checks++;
            if ({tap_out, tap_valid} !== {etap[s], 1'b1}) begin
                errors++;
                $display("FAIL tap sel %0d: data=%h valid=%b, need %h 1", s, tap_out, tap_valid, etap[s]);
            end
        end
        tap_sel3 = 2'd0;
        #1;
        checks++;
        if ({tap_out3, tap_valid3} !== {8'h04, 1'b1}) begin
            errors++;
            $display("FAIL tap3 sel 0: data=%h valid=%b, need 04 1", tap_out3, tap_valid3);
        end
        tap_sel3 = 2'd3;
        #1;
        checks++;
        if ({tap_out3, tap_valid3} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL tap3 sel 3: data=%h valid=%b, need 00 0", tap_out3, tap_valid3);
        end
    endtask

    task automatic test_reset_midstream();
        do_flush();
        enable = 1'b1; valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = 8'(8'h30 + k);
            tick();
        end
        checks++;
        if (occ !== 3'd3) begin
            errors++;
            $display("FAIL midreset prefill: occ=%0d, need 3", occ);
        end
        sys_reset = 1'b1; data_in = 8'hEE;
        tick();
        sys_reset = 1'b0;
        checks++;
        if ({occ, valid_out, empty} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset clear: occ=%0d vout=%b empty=%b, need 0 0 1", occ, valid_out, empty);
        end
        data_in = 8'h7E;
        for (int k = 1; k <= 4; k++) begin
            tick();
            valid_in = 1'b0; data_in = 8'h00;
            checks++;
            if ({data_out, valid_out} !== {(k == 4) ? 8'h7E : 8'h00, k == 4}) begin
                errors++;
                $display("FAIL midreset latency edge %0d: dout=%h vout=%b", k, data_out, valid_out);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_bubbles();
        test_flush_priority();
        test_tap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
